// File: rtl/iq_downconverter_pkg.sv
// Shared types and helpers for the fs/4 I/Q downconverter.
// The optional error counter (IQ_DOWNCONV_ERR_CNT_EN) needs nothing from this package.
package iq_downconv_pkg;

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam int CHIPS = 4;
    localparam int OFF_W = $clog2(CHIPS);

    // Aligned training chips: I=1, Q=0 -> (I, ~Q, ~I, Q) = 1,1,0,0 with bit0 first.
    localparam logic [CHIPS-1:0] TRAIN_WORD_DEFAULT = 4'b0011;

    // The LO chip pattern repeats each data bit inverted two chips later.
    function automatic logic chip_check(input logic [CHIPS-1:0] c);
        return (c[0] != c[2]) && (c[1] != c[3]);
    endfunction

endpackage

// File: rtl/iq_downconverter_if.sv
// Chip-word input and recovered-symbol output bundle of the downconverter.
// err_count exists only when IQ_DOWNCONV_ERR_CNT_EN is defined.
interface iq_downconverter_if;

    // rx_word is sampled only on beats with rx_valid=1; there is no backpressure,
    // and data_valid is a single-cycle strobe that qualifies data_i/data_q/sym_err.
    logic [3:0] rx_word;
    logic       rx_valid;
    logic       data_i;
    logic       data_q;
    logic       data_valid;
    logic       locked;
    logic [1:0] offset;
    logic       sym_err;
`ifdef IQ_DOWNCONV_ERR_CNT_EN
    logic [15:0] err_count;

    modport master (
        output rx_word, rx_valid,
        input  data_i, data_q, data_valid, locked, offset, sym_err, err_count
    );

    modport slave (
        input  rx_word, rx_valid,
        output data_i, data_q, data_valid, locked, offset, sym_err, err_count
    );
`else
    modport master (
        output rx_word, rx_valid,
        input  data_i, data_q, data_valid, locked, offset, sym_err
    );

    modport slave (
        input  rx_word, rx_valid,
        output data_i, data_q, data_valid, locked, offset, sym_err
    );
`endif

endinterface

// File: rtl/iq_downconverter_aligner.sv
// Holds the previous valid chip word and extracts the four candidate aligned words
// from the 8-chip window {rx_word, prev}.
module iq_chip_aligner
    import iq_downconv_pkg::*;
(
    input  logic                        aclk,
    input  logic                        rst,
    input  logic [CHIPS-1:0]            rx_word,
    input  logic                        rx_valid,
    input  logic [OFF_W-1:0]            sel,
    output logic [CHIPS-1:0][CHIPS-1:0] aligned_all,
    output logic [CHIPS-1:0]            aligned_sel
);

    logic [CHIPS-1:0]   prev_q;
    logic [CHIPS-1:0]   prev_d;
    logic [2*CHIPS-1:0] window;

    always_comb begin
        prev_d = prev_q;
        if (rx_valid) begin
            prev_d = rx_word;
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign window = {rx_word, prev_q};

    always_comb begin
        aligned_all = '0;
        for (int k = 0; k < CHIPS; k++) begin
            aligned_all[k] = window[k +: CHIPS];
        end
    end

    assign aligned_sel = aligned_all[sel];

endmodule

// File: rtl/iq_downconverter.sv
// fs/4 I/Q downconverter: training-pattern symbol alignment, I/Q recovery and lock
// supervision. Define IQ_DOWNCONV_ERR_CNT_EN to add the err_count output.
module iq_downconverter
    import iq_downconv_pkg::*;
#(
    parameter int               LOCK_COUNT  = 16,
    parameter int               UNLOCK_ERRS = 8,
    parameter logic [CHIPS-1:0] TRAIN_WORD  = TRAIN_WORD_DEFAULT
) (
    input  logic             aclk,
    input  logic             rst,
    iq_downconverter_if.slave bus
);

    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int EW = $clog2(UNLOCK_ERRS + 1);
    localparam logic [MW-1:0] LOCK_MAX = MW'(LOCK_COUNT);
    localparam logic [EW-1:0] ERR_MAX  = EW'(UNLOCK_ERRS);

    state_t                     state_q, state_d;
    logic [OFF_W-1:0]           offset_q, offset_d;
    logic [CHIPS-1:0][MW-1:0]   match_cnt_q, match_cnt_d;
    logic [EW-1:0]              err_run_q, err_run_d;
    logic                       data_i_q, data_i_d;
    logic                       data_q_q, data_q_d;
    logic                       data_valid_q, data_valid_d;
    logic                       sym_err_q, sym_err_d;
    logic [CHIPS-1:0][CHIPS-1:0] aligned_all;
    logic [CHIPS-1:0]           aligned_sel;
    logic                       sym_ok;
    logic                       hit;
    logic [OFF_W-1:0]           hit_k;
`ifdef IQ_DOWNCONV_ERR_CNT_EN
    logic [15:0]                err_count_q, err_count_d;
`endif

    iq_chip_aligner u_aligner (
        .aclk        (aclk),
        .rst         (rst),
        .rx_word     (bus.rx_word),
        .rx_valid    (bus.rx_valid),
        .sel         (offset_q),
        .aligned_all (aligned_all),
        .aligned_sel (aligned_sel)
    );

    assign sym_ok = chip_check(aligned_sel);

    always_comb begin
        state_d      = state_q;
        offset_d     = offset_q;
        match_cnt_d  = match_cnt_q;
        err_run_d    = err_run_q;
        data_i_d     = data_i_q;
        data_q_d     = data_q_q;
        data_valid_d = 1'b0;
        sym_err_d    = 1'b0;
        hit          = 1'b0;
        hit_k        = '0;
`ifdef IQ_DOWNCONV_ERR_CNT_EN
        err_count_d  = err_count_q;
`endif
        if (bus.rx_valid) begin
            case (state_q)
                SEARCH: begin
                    for (int k = 0; k < CHIPS; k++) begin
                        if (aligned_all[k] == TRAIN_WORD) begin
                            match_cnt_d[k] = (match_cnt_q[k] == LOCK_MAX) ? LOCK_MAX
                                                                          : match_cnt_q[k] + 1'b1;
                        end else begin
                            match_cnt_d[k] = '0;
                        end
                    end
                    // Scan from the top so the lowest qualifying offset is the last written.
                    for (int k = CHIPS - 1; k >= 0; k--) begin
                        if (match_cnt_d[k] == LOCK_MAX) begin
                            hit   = 1'b1;
                            hit_k = OFF_W'(k);
                        end
                    end
                    if (hit) begin
                        state_d     = LOCKED;
                        offset_d    = hit_k;
                        match_cnt_d = '0;
                        err_run_d   = '0;
`ifdef IQ_DOWNCONV_ERR_CNT_EN
                        err_count_d = '0;
`endif
                    end
                end
                LOCKED: begin
                    data_i_d     = aligned_sel[0];
                    data_q_d     = aligned_sel[CHIPS-1];
                    sym_err_d    = ~sym_ok;
                    data_valid_d = 1'b1;
                    if (sym_ok) begin
                        err_run_d = '0;
                    end else begin
                        err_run_d = (err_run_q == ERR_MAX) ? ERR_MAX : err_run_q + 1'b1;
`ifdef IQ_DOWNCONV_ERR_CNT_EN
                        err_count_d = (err_count_q == 16'hFFFF) ? err_count_q
                                                                : err_count_q + 16'd1;
`endif
                    end
                    // The symbol that hits the limit is still emitted; the search restarts after it.
                    if (err_run_d == ERR_MAX) begin
                        state_d     = SEARCH;
                        match_cnt_d = '0;
                        err_run_d   = '0;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (rst) begin
            state_q      <= SEARCH;
            offset_q     <= '0;
            match_cnt_q  <= '0;
            err_run_q    <= '0;
            data_i_q     <= 1'b0;
            data_q_q     <= 1'b0;
            data_valid_q <= 1'b0;
            sym_err_q    <= 1'b0;
`ifdef IQ_DOWNCONV_ERR_CNT_EN
            err_count_q  <= '0;
`endif
        end else begin
            state_q      <= state_d;
            offset_q     <= offset_d;
            match_cnt_q  <= match_cnt_d;
            err_run_q    <= err_run_d;
            data_i_q     <= data_i_d;
            data_q_q     <= data_q_d;
            data_valid_q <= data_valid_d;
            sym_err_q    <= sym_err_d;
`ifdef IQ_DOWNCONV_ERR_CNT_EN
            err_count_q  <= err_count_d;
`endif
        end
    end

    assign bus.data_i     = data_i_q;
    assign bus.data_q     = data_q_q;
    assign bus.data_valid = data_valid_q;
    assign bus.locked     = (state_q == LOCKED);
    assign bus.offset     = offset_q;
    assign bus.sym_err    = sym_err_q;
`ifdef IQ_DOWNCONV_ERR_CNT_EN
    assign bus.err_count  = err_count_q;
`endif

endmodule

// File: tb/tb_iq_downconverter.sv
// Directed bench for iq_downconverter: lock at offsets 0 and 1, error-driven unlock,
// gapped rx_valid, reset while locked, and err_count when IQ_DOWNCONV_ERR_CNT_EN is set.
module tb_iq_downconverter;

  logic aclk = 1'b0;
  logic rst  = 1'b1;

  always #5 aclk = ~aclk;

  iq_downconverter_if bus();

  iq_downconverter dut (
    .aclk (aclk),
    .rst  (rst),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [3:0] last_sym;
  logic [3:0] sym;
  logic       cur_i, cur_q, exp_i, exp_q;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One aclk: drive a word, then sample 1 time unit after the rising edge.
  task automatic beat(input logic [3:0] w, input logic v);
    bus.rx_word  = w;
    bus.rx_valid = v;
    @(posedge aclk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic ev, input logic ei, input logic eq,
                            input logic ee, input logic el);
    chk({tag, ".data_valid"}, 16'(bus.data_valid), 16'(ev));
    if (ev) begin
      chk({tag, ".data_i"}, 16'(bus.data_i), 16'(ei));
      chk({tag, ".data_q"}, 16'(bus.data_q), 16'(eq));
      chk({tag, ".sym_err"}, 16'(bus.sym_err), 16'(ee));
    end
    chk({tag, ".locked"}, 16'(bus.locked), 16'(el));
  endtask

  // Chips for one symbol, bit0 first: I, ~Q, ~I, Q.
  function automatic logic [3:0] sym_of(input logic i, input logic q);
    return {q, ~i, ~q, i};
  endfunction

  initial begin
    bus.rx_word  = 4'b0000;
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge aclk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst.locked", 16'(bus.locked), 16'h0);
    chk("rst.data_valid", 16'(bus.data_valid), 16'h0);
    chk("rst.offset", 16'(bus.offset), 16'h0);
    chk("rst.sym_err", 16'(bus.sym_err), 16'h0);
    chk("rst.data_i", 16'(bus.data_i), 16'h0);
    chk("rst.data_q", 16'(bus.data_q), 16'h0);
`ifdef IQ_DOWNCONV_ERR_CNT_EN
    chk("rst.err_count", bus.err_count, 16'd0);
`endif

    // Offset 0: 16 training words then 1001; the 16th match lands on the 1001 beat.
    for (int n = 0; n < 16; n++) begin
      beat(4'b0011, 1'b1);
      expect_out("t1.train", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    beat(4'b1001, 1'b1);
    expect_out("t1.lock", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t1.offset", 16'(bus.offset), 16'h0);
    beat(4'b0011, 1'b1);
    expect_out("t1.data11", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);

    // Seven errors then a good symbol keeps lock (offset 0 outputs the previous word).
    beat(4'b0000, 1'b1);
    expect_out("t3.train_sym", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 6; n++) begin
      beat(4'b0000, 1'b1);
      expect_out("t3.err7", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    beat(4'b1001, 1'b1);
    expect_out("t3.err7_last", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    beat(4'b0011, 1'b1);
    expect_out("t3.good", 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
`ifdef IQ_DOWNCONV_ERR_CNT_EN
    chk("t3.err_count7", bus.err_count, 16'd7);
`endif

    // Eight consecutive errors: lock drops in the cycle that shows the 8th error.
    beat(4'b0000, 1'b1);
    expect_out("t3.pre", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int n = 0; n < 7; n++) begin
      beat(4'b0000, 1'b1);
      expect_out("t3.err8", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    end
    beat(4'b0000, 1'b1);
    expect_out("t3.unlock", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("t3.offset_held", 16'(bus.offset), 16'h0);
`ifdef IQ_DOWNCONV_ERR_CNT_EN
    chk("t3.err_count15", bus.err_count, 16'd15);
`endif

    // Gapped training: 17 valid words (first one sees prev=0000), idle beats between.
    for (int n = 1; n <= 17; n++) begin
      beat(4'b0011, 1'b1);
      expect_out("t4.valid", 1'b0, 1'b0, 1'b0, 1'b0, n == 17);
      beat(4'b1111, 1'b0);
      expect_out("t4.idle", 1'b0, 1'b0, 1'b0, 1'b0, n == 17);
    end
    chk("t4.offset", 16'(bus.offset), 16'h0);
`ifdef IQ_DOWNCONV_ERR_CNT_EN
    chk("t4.err_count_cleared", bus.err_count, 16'd0);
`endif

    // Three error symbols after re-lock; training symbols decode as I=1, Q=0.
    beat(4'b0000, 1'b1);
    expect_out("t6.train_sym", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    beat(4'b0000, 1'b1);
    expect_out("t6.err1", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    beat(4'b0011, 1'b1);
    expect_out("t6.err2", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    beat(4'b0011, 1'b1);
    expect_out("t6.good", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
`ifdef IQ_DOWNCONV_ERR_CNT_EN
    chk("t6.err_count2", bus.err_count, 16'd2);
`endif
    beat(4'b0000, 1'b1);
    expect_out("t6.train2", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    beat(4'b0011, 1'b1);
    expect_out("t6.err3", 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
`ifdef IQ_DOWNCONV_ERR_CNT_EN
    chk("t6.err_count3", bus.err_count, 16'd3);
`endif

    // Offset 1: stream delayed by one chip, each word = {sym[2:0], previous sym[3]}.
    rst = 1'b1;
    beat(4'b0000, 1'b1);
    rst = 1'b0;
    last_sym = 4'b0000;
    sym      = sym_of(1'b1, 1'b0);
    for (int n = 1; n <= 17; n++) begin
      beat({sym[2:0], last_sym[3]}, 1'b1);
      last_sym = sym;
      expect_out("t2.train", 1'b0, 1'b0, 1'b0, 1'b0, n == 17);
    end
    chk("t2.offset", 16'(bus.offset), 16'h1);
    exp_i = 1'b1;
    exp_q = 1'b0;
    for (int n = 0; n < 20; n++) begin
      cur_i = 1'($urandom_range(0, 1));
      cur_q = 1'($urandom_range(0, 1));
      sym   = sym_of(cur_i, cur_q);
      beat({sym[2:0], last_sym[3]}, 1'b1);
      expect_out("t2.data", 1'b1, exp_i, exp_q, 1'b0, 1'b1);
      exp_i    = cur_i;
      exp_q    = cur_q;
      last_sym = sym;
    end

    // Reset pulse while locked at offset 1.
    rst = 1'b1;
    beat(4'b0011, 1'b1);
    rst = 1'b0;
    expect_out("t5.rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("t5.offset", 16'(bus.offset), 16'h0);
    chk("t5.data_i", 16'(bus.data_i), 16'h0);
    chk("t5.data_q", 16'(bus.data_q), 16'h0);
    chk("t5.sym_err", 16'(bus.sym_err), 16'h0);
`ifdef IQ_DOWNCONV_ERR_CNT_EN
    chk("t5.err_count", bus.err_count, 16'd0);
`endif
    beat(4'b0011, 1'b0);
    expect_out("t5.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int n = 1; n <= 17; n++) begin
      beat(4'b0011, 1'b1);
      expect_out("t5.relock", 1'b0, 1'b0, 1'b0, 1'b0, n == 17);
    end
    chk("t5.offset_relock", 16'(bus.offset), 16'h0);
    beat(4'b1001, 1'b1);
    expect_out("t5.data", 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
